// File: rtl/fu_result_queue.sv
// fu_result_queue: in-order FIFO holding completed FU packets until the CDB arbiter grants them
module fu_result_queue #(
  parameter int DEPTH = 4,
  parameter int PKT_W = 38,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [PKT_W-1:0] din,
  output logic             ready,
  output logic             valid_out,
  output logic [PKT_W-1:0] dout,
  input  logic             yumi_in,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic clr, enq, deq;
  assign ready     = count_q != CNT_W'(DEPTH);
  assign valid_out = count_q != '0;
  assign dout      = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign clr = reset | flush;
  assign enq = valid_in & ready & ~clr;
  assign deq = yumi_in & valid_out & ~clr;
  // flush squashes contents but keeps the sticky overflow flag
  always_comb begin
    rd_ptr_d   = clr ? '0 : rd_ptr_q + AW'(deq);
    wr_ptr_d   = clr ? '0 : wr_ptr_q + AW'(enq);
    count_d    = clr ? '0 : count_q + CNT_W'(enq) - CNT_W'(deq);
    overflow_d = reset ? 1'b0 : overflow_q | (valid_in & ~ready & ~flush);
  end
  always_ff @(posedge clk) begin
    rd_ptr_q   <= rd_ptr_d;
    wr_ptr_q   <= wr_ptr_d;
    count_q    <= count_d;
    overflow_q <= overflow_d;
  end
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: tb/tb_fu_result_queue.sv
// tb_fu_result_queue: table-driven directed checks of the FU result queue
module tb_fu_result_queue;
  logic clk = 0, reset, flush, valid_in, yumi_in;
  logic [37:0] din, dout;
  logic ready, valid_out, overflow;
  logic [2:0] count;
  int passed = 0, total = 0;

  fu_result_queue dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .din(din),
    .ready(ready), .valid_out(valid_out), .dout(dout), .yumi_in(yumi_in),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, fl, vi;
    logic [37:0] d;
    logic yu, er, ev;
    logic [2:0] ec;
    logic eo, cd;
    logic [37:0] ed;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step(input logic r, input logic f, input logic v, input logic [37:0] d, input logic y);
    reset = r; flush = f; valid_in = v; din = d; yumi_in = y;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic er, input logic ev, input logic [2:0] ec,
                            input logic eo, input logic cd, input logic [37:0] ed);
    chk({tag, ".ready"}, 64'(ready), 64'(er));
    chk({tag, ".valid_out"}, 64'(valid_out), 64'(ev));
    chk({tag, ".count"}, 64'(count), 64'(ec));
    chk({tag, ".overflow"}, 64'(overflow), 64'(eo));
    if (cd) chk({tag, ".dout"}, 64'(dout), 64'(ed));
  endtask

  initial begin
    reset = 1; flush = 0; valid_in = 0; yumi_in = 0; din = '0;
    //               rst fl vi  d      yu er ev cnt ov cd dout
    tbl.push_back('{1, 0, 0, 38'h0,  0, 1, 0, 0, 0, 0, 38'h0});
    tbl.push_back('{0, 0, 0, 38'h0,  1, 1, 0, 0, 0, 0, 38'h0});
    tbl.push_back('{0, 0, 1, 38'hA,  0, 1, 1, 1, 0, 1, 38'hA});
    tbl.push_back('{0, 0, 1, 38'hB,  0, 1, 1, 2, 0, 1, 38'hA});
    tbl.push_back('{0, 0, 1, 38'hC,  0, 1, 1, 3, 0, 1, 38'hA});
    tbl.push_back('{0, 0, 1, 38'hD,  0, 0, 1, 4, 0, 1, 38'hA});
    tbl.push_back('{0, 0, 0, 38'h0,  1, 1, 1, 3, 0, 1, 38'hB});
    tbl.push_back('{0, 0, 0, 38'h0,  1, 1, 1, 2, 0, 1, 38'hC});
    tbl.push_back('{0, 0, 0, 38'h0,  1, 1, 1, 1, 0, 1, 38'hD});
    tbl.push_back('{0, 0, 0, 38'h0,  1, 1, 0, 0, 0, 0, 38'h0});
    tbl.push_back('{0, 0, 1, 38'h11, 0, 1, 1, 1, 0, 1, 38'h11});
    tbl.push_back('{0, 0, 1, 38'h12, 0, 1, 1, 2, 0, 1, 38'h11});
    tbl.push_back('{0, 0, 1, 38'h13, 1, 1, 1, 2, 0, 1, 38'h12});
    tbl.push_back('{0, 0, 1, 38'h14, 1, 1, 1, 2, 0, 1, 38'h13});
    tbl.push_back('{0, 0, 1, 38'h15, 1, 1, 1, 2, 0, 1, 38'h14});
    tbl.push_back('{0, 0, 0, 38'h0,  1, 1, 1, 1, 0, 1, 38'h15});
    tbl.push_back('{0, 0, 0, 38'h0,  1, 1, 0, 0, 0, 0, 38'h0});
    tbl.push_back('{0, 0, 1, 38'h21, 0, 1, 1, 1, 0, 1, 38'h21});
    tbl.push_back('{0, 0, 1, 38'h22, 0, 1, 1, 2, 0, 1, 38'h21});
    tbl.push_back('{0, 0, 1, 38'h23, 0, 1, 1, 3, 0, 1, 38'h21});
    tbl.push_back('{0, 0, 1, 38'h24, 0, 0, 1, 4, 0, 1, 38'h21});
    tbl.push_back('{0, 0, 1, 38'h25, 0, 0, 1, 4, 1, 1, 38'h21});
    tbl.push_back('{0, 0, 0, 38'h0,  1, 1, 1, 3, 1, 1, 38'h22});
    tbl.push_back('{0, 1, 1, 38'h26, 1, 1, 0, 0, 1, 0, 38'h0});
    tbl.push_back('{0, 0, 0, 38'h0,  1, 1, 0, 0, 1, 0, 38'h0});
    tbl.push_back('{1, 0, 0, 38'h0,  0, 1, 0, 0, 0, 0, 38'h0});
    tbl.push_back('{0, 0, 1, 38'h31, 0, 1, 1, 1, 0, 1, 38'h31});
    tbl.push_back('{0, 0, 1, 38'h32, 0, 1, 1, 2, 0, 1, 38'h31});
    tbl.push_back('{0, 0, 1, 38'h33, 0, 1, 1, 3, 0, 1, 38'h31});
    tbl.push_back('{0, 0, 1, 38'h34, 0, 0, 1, 4, 0, 1, 38'h31});
    tbl.push_back('{0, 0, 1, 38'h35, 1, 1, 1, 3, 1, 1, 38'h32});
    tbl.push_back('{0, 0, 0, 38'h0,  1, 1, 1, 2, 1, 1, 38'h33});
    tbl.push_back('{0, 0, 0, 38'h0,  1, 1, 1, 1, 1, 1, 38'h34});
    tbl.push_back('{0, 0, 0, 38'h0,  1, 1, 0, 0, 1, 0, 38'h0});
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].fl, tbl[i].vi, tbl[i].d, tbl[i].yu);
      expect_out($sformatf("vec%0d", i), tbl[i].er, tbl[i].ev, tbl[i].ec, tbl[i].eo, tbl[i].cd, tbl[i].ed);
    end
    // reset mid-operation drops buffered packets and the coincident input
    step(0, 0, 1, 38'h41, 0);
    step(0, 0, 1, 38'h42, 0);
    expect_out("pre_reset", 1, 1, 2, 1, 1, 38'h41);
    step(1, 0, 1, 38'h43, 1);
    expect_out("mid_reset", 1, 0, 0, 0, 0, 38'h0);
    // enqueue while empty appears after one edge; yumi on empty is ignored
    step(0, 0, 1, 38'h44, 1);
    expect_out("empty_enq_yumi", 1, 1, 1, 0, 1, 38'h44);
    step(0, 0, 0, 38'h0, 0);
    expect_out("hold_head", 1, 1, 1, 0, 1, 38'h44);
    // flush with valid_in on a non-full queue must not set overflow
    step(0, 1, 1, 38'h45, 0);
    expect_out("flush_no_ovf", 1, 0, 0, 0, 0, 38'h0);
    step(0, 0, 1, 38'h46, 0);
    expect_out("post_flush_enq", 1, 1, 1, 0, 1, 38'h46);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
